// File: rtl/fwd_ctrl_unit.sv
// rtl/fwd_ctrl_unit.sv - operand-forwarding select and load-use stall control beside ID/EX
// Optional stall counter output stall_cnt_o is enabled by defining FWD_PERF_CNT_EN.
module fwd_ctrl_unit #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs1_i,
  input  logic [ADDR_W-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [ADDR_W-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_memread;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic              wb_regwrite;
  logic              wb_memread;

  logic ex_hit_a;
  logic ex_hit_b;
  logic mem_hit_a;
  logic mem_hit_b;
  logic load_use;
  logic ex_load;
  logic [1:0] sel_a_d;
  logic [1:0] sel_b_d;

  // A record only forwards if it really writes a non-x0 register the consumer reads.
  assign ex_hit_a  = id_rs1_used_i & ex_valid & ex_regwrite & (ex_rd != '0) & (ex_rd == id_rs1_i);
  assign ex_hit_b  = id_rs2_used_i & ex_valid & ex_regwrite & (ex_rd != '0) & (ex_rd == id_rs2_i);
  assign mem_hit_a = id_rs1_used_i & mem_valid & mem_regwrite & (mem_rd != '0) & (mem_rd == id_rs1_i);
  assign mem_hit_b = id_rs2_used_i & mem_valid & mem_regwrite & (mem_rd != '0) & (mem_rd == id_rs2_i);

  assign load_use = id_valid_i & ~flush_i & ex_valid & ex_memread & (ex_rd != '0)
                  & ((id_rs1_used_i & (ex_rd == id_rs1_i)) | (id_rs2_used_i & (ex_rd == id_rs2_i)));

  assign stall_o = load_use;
  assign ex_load = ~load_use & ~flush_i;

  always_comb begin
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (ex_load && id_valid_i) begin
      if (ex_hit_a) begin
        sel_a_d = SEL_ALU;
      end else if (mem_hit_a) begin
        sel_a_d = SEL_WB;
      end
      if (ex_hit_b) begin
        sel_b_d = SEL_ALU;
      end else if (mem_hit_b) begin
        sel_b_d = SEL_WB;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_valid     <= 1'b0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_valid    <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
      wb_memread   <= 1'b0;
      fwd_a_sel_o  <= SEL_RF;
      fwd_b_sel_o  <= SEL_RF;
    end else begin
      wb_valid     <= mem_valid;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      wb_memread   <= mem_memread;
      mem_valid    <= ex_valid;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      mem_memread  <= ex_memread;
      if (ex_load) begin
        ex_valid    <= id_valid_i;
        ex_rd       <= id_rd_i;
        ex_regwrite <= id_regwrite_i;
        ex_memread  <= id_memread_i;
      end else begin
        ex_valid    <= 1'b0;
        ex_rd       <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end
      fwd_a_sel_o <= sel_a_d;
      fwd_b_sel_o <= sel_b_d;
    end
  end

  // The WB record is kept for pipeline visibility; no select path reads it.
  logic unused_rec;
  assign unused_rec = ^{wb_valid, wb_rd, wb_regwrite, wb_memread, mem_memread};

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// tb/tb_fwd_ctrl_unit.sv - scoreboard bench for fwd_ctrl_unit against a producer-distance model
module tb_fwd_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       id_valid_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_rs1_used_i;
  logic       id_rs2_used_i;
  logic [4:0] id_rd_i;
  logic       id_regwrite_i;
  logic       id_memread_i;
  logic       flush_i;
  logic       stall_o;
  logic [1:0] fwd_a_sel_o;
  logic [1:0] fwd_b_sel_o;
`ifdef FWD_PERF_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  fwd_ctrl_unit #(.ADDR_W(5), .CNT_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .fwd_a_sel_o   (fwd_a_sel_o),
    .fwd_b_sel_o   (fwd_b_sel_o)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // An instruction that has entered EX; newest first, index = distance from the consumer.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [15:0] cnt;
  } exp_t;

  localparam instr_t BUBBLE = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};

  instr_t hist[$];
  exp_t   exp_q[$];
  exp_t   pend;
  logic   have_pend = 1'b0;
  logic   done = 1'b0;
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  logic [15:0] cnt_model = 16'd0;

  function automatic logic [1:0] fwd_code(input logic [4:0] r, input logic used);
    fwd_code = 2'b00;
    if (used && r != 5'd0) begin
      for (int d = 1; d >= 0; d--) begin
        if (hist[d].v && hist[d].rw && hist[d].rd == r) fwd_code = (d == 0) ? 2'b10 : 2'b01;
      end
    end
  endfunction

  task automatic cycle(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl, input logic rst,
                       output logic st);
    exp_t   e;
    logic   issue;
    instr_t ni;
    id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2;
    id_rs1_used_i = u1; id_rs2_used_i = u2; id_rd_i = rd;
    id_regwrite_i = rw; id_memread_i = mr; flush_i = fl; rst_i = rst;
    st = v && !fl && hist[0].v && hist[0].mr && hist[0].rd != 5'd0 &&
         ((u1 && hist[0].rd == rs1) || (u2 && hist[0].rd == rs2));
    issue = rst && !st && !fl;
    e.stall = st;
    e.a = (issue && v) ? fwd_code(rs1, u1) : 2'b00;
    e.b = (issue && v) ? fwd_code(rs2, u2) : 2'b00;
    if (!rst) e.cnt = 16'd0;
    else if (st && cnt_model != 16'hffff) e.cnt = cnt_model + 16'd1;
    else e.cnt = cnt_model;
    exp_q.push_back(e);
    ni = issue ? instr_t'{v: v, rd: rd, rw: rw, mr: mr} : BUBBLE;
    @(posedge clk);
    if (!rst) begin
      hist = '{BUBBLE, BUBBLE};
    end else begin
      hist.push_front(ni);
      void'(hist.pop_back());
    end
    cnt_model = e.cnt;
    cyc++;
    #1;
  endtask

  // Re-presents the ID instruction while it is held by a stall, as IF/ID would.
  task automatic run(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic fl);
    logic st;
    int   tries = 0;
    do begin
      cycle(v, rs1, rs2, u1, u2, rd, rw, mr, fl, 1'b1, st);
      tries++;
    end while (st && tries < 4);
    if (st) begin
      errors++;
      $display("FAIL stall_bound cyc=%0d got=still_stalled want=released", cyc);
    end
  endtask

  always @(negedge clk) begin
    if (have_pend) begin
      checks += 2;
      if (fwd_a_sel_o !== pend.a) begin
        errors++;
        $display("FAIL fwd_a_sel cyc=%0d got=%b want=%b", cyc, fwd_a_sel_o, pend.a);
      end
      if (fwd_b_sel_o !== pend.b) begin
        errors++;
        $display("FAIL fwd_b_sel cyc=%0d got=%b want=%b", cyc, fwd_b_sel_o, pend.b);
      end
`ifdef FWD_PERF_CNT_EN
      checks++;
      if (stall_cnt_o !== pend.cnt) begin
        errors++;
        $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", cyc, stall_cnt_o, pend.cnt);
      end
`endif
      have_pend = 1'b0;
    end
    if (exp_q.size() > 0) begin
      pend = exp_q.pop_front();
      have_pend = 1'b1;
      checks++;
      if (stall_o !== pend.stall) begin
        errors++;
        $display("FAIL stall cyc=%0d got=%b want=%b", cyc, stall_o, pend.stall);
      end
    end else if (!done) begin
      errors++;
      $display("FAIL scoreboard_underrun cyc=%0d got=empty want=entry", cyc);
    end
  end

  initial begin
    logic st;
    hist = '{BUBBLE, BUBBLE};
    rst_i = 1'b0; id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0; id_rd_i = '0;
    id_regwrite_i = 1'b0; id_memread_i = 1'b0; flush_i = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, st);
    cycle(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, st);

    // add x5 ; sub rs1=x5
    run(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    run(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    // add x5 ; nop ; and rs2=x5
    run(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    run(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    run(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    // add x5 ; add x5 ; consumer rs1=x5
    run(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    run(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    run(1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    // lw x7 ; add rs1=x7
    run(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    run(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    // producer to x0 ; consumer of x0 ; lw x7 ; flushed consumer
    run(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    run(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    run(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    run(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1);
    run(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    // reset landing on a load-use stall cycle, then the hazard again
    run(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, st);
    run(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
    run(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    run(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'b1, 1'b1, 5'($urandom_range(0, 7)), 1'b1, 1'($urandom_range(0, 1)),
              1'b0, 1'b0, st);
      end else begin
        run(1'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
      end
    end

    done = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
